axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares the single sram-like read channel of the AXI read/write interface between the icache and dcache read requesters.
- Each grant is held for a whole transaction, from the request handshake through the beat carrying rlast.
- Dcache has fixed priority; an aging counter keeps instruction fetch from starving.
- Sits between the cache read ports and the AXI interface's sram-like read port. The write path does not pass through this block.

Parameters:
- STARVE_LIMIT, 16: icache wait cycles after which icache beats dcache at the next arbitration.
- CNT_W, 8: width of the icache wait counter. STARVE_LIMIT must be less than 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- icache_rd_req  in  1  icache read request
- icache_rd_addr  in  64  icache read address
- icache_rd_type  in  3  0:1B 1:2B 2:4B 3:8B 4:cache line
- icache_rd_ready  out  1  icache request accepted this cycle
- icache_rdata  out  64  icache return data
- icache_rlast  out  1  icache last beat
- icache_rvalid  out  1  icache beat valid
- dcache_rd_req / dcache_rd_addr / dcache_rd_type / dcache_rd_ready / dcache_rdata / dcache_rlast / dcache_rvalid  same directions, widths and meanings as the icache set
- rd_req  out  1  request to the AXI interface
- rd_addr  out  64  forwarded address
- rd_type  out  3  forwarded type
- rd_ready  in  1  AXI interface accepts the request
- rdata  in  64  beat data
- rlast  in  1  last beat
- rvalid  in  1  beat valid
- owner  out  2  00 none, 01 icache, 10 dcache
- arb_err  out  1  sticky: a beat arrived with no owner

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset value is IDLE, which also gives owner=00.
- Reset values: wait_cnt=0, arb_err=0, every *_ready/*_rvalid/*_rlast output 0, every rdata output 0.
- Winner selection in IDLE:
  - Only one requester: it wins.
  - Both requesting: dcache wins unless wait_cnt >= STARVE_LIMIT, in which case icache wins.
- Forwarding in IDLE (combinational):
  - rd_req = winner req; rd_addr/rd_type = winner's fields; winner *_rd_ready = rd_ready; loser ready = 0.
  - No requester: rd_req=0, rd_addr=0, rd_type=0.
- Handshake rd_req && rd_ready -> BUSY_I or BUSY_D next cycle.
- In BUSY_x:
  - rd_req=0 and both readys=0; requesters hold their req until they get ready.
  - rvalid/rlast/rdata are routed to the owner only. The non-owner sees rvalid=0, rlast=0, rdata=0.
  - Routing is combinational, zero latency.
- rvalid && rlast in BUSY_x -> IDLE next cycle. This forces one bubble cycle; there is no regrant in the same cycle.
- rvalid in IDLE: the beat is dropped and arb_err is set; arb_err clears only on rst.
- wait_cnt:
  - Increments (saturating at 2^CNT_W-1) on each cycle icache_rd_req=1 and icache is not handshaking: in IDLE while dcache wins or rd_ready=0, and in BUSY_D.
  - Clears on the icache handshake.
  - Holds otherwise.
- A requester dropping req before its handshake is legal; arbitration re-evaluates every IDLE cycle.
- Reset mid-burst: return to IDLE. Remaining beats arriving after reset set arb_err; the interface side is reset in the same cycle.
- owner reflects the registered state: 01 in BUSY_I, 10 in BUSY_D, 00 otherwise.

Decomposition:
- Shared package:
  - rd_type encodings (RD_TYPE_B1/B2/B4/B8/LINE)
  - owner encodings
  - FSM state localparams
  - AXI burst-type constants, shared with the AXI interface
- One natural sub-module: rd_age_counter (saturating wait counter with clear and increment, plus a >= STARVE_LIMIT compare).

Test Plan:
1. Dcache alone, type 4, addr 0x8000_0040; rd_ready=1 -> handshake in cycle 1, owner=10 in cycle 2. Two beats with rlast on the second -> IDLE; icache rvalid stays 0 throughout.
2. Simultaneous icache and dcache requests, wait_cnt=0 -> dcache granted, icache_rd_ready=0. After the dcache rlast there is one bubble cycle, then icache is granted.
3. Dcache requests continuously while icache waits 16 cycles with STARVE_LIMIT=16 -> the next IDLE arbitration grants icache even though dcache is requesting; wait_cnt returns to 0 after the handshake.
4. rd_ready held low for 5 cycles while icache requests -> rd_req=1 and rd_addr stable, icache_rd_ready=0, no state change; grant occurs in the cycle rd_ready rises.
5. rvalid=1 pulsed while in IDLE -> no requester sees rvalid; arb_err=1 and stays 1 until rst.
6. rst asserted in BUSY_I after 1 of 2 beats -> next cycle IDLE, owner=00, all outputs at their reset values. A new dcache request is then granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the cache read-channel arbiter and the AXI interface it feeds.
// Holds the request-type and owner encodings, the arbiter FSM states and the AXI burst types.
package axi_rd_arbiter_pkg;

    localparam int unsigned RD_ADDR_W = 64;
    localparam int unsigned RD_DATA_W = 64;
    localparam int unsigned RD_TYPE_W = 3;

    // Request size encodings on *_rd_type.
    localparam logic [RD_TYPE_W-1:0] RD_TYPE_B1   = 3'd0;
    localparam logic [RD_TYPE_W-1:0] RD_TYPE_B2   = 3'd1;
    localparam logic [RD_TYPE_W-1:0] RD_TYPE_B4   = 3'd2;
    localparam logic [RD_TYPE_W-1:0] RD_TYPE_B8   = 3'd3;
    localparam logic [RD_TYPE_W-1:0] RD_TYPE_LINE = 3'd4;

    localparam logic [1:0] OWNER_NONE   = 2'b00;
    localparam logic [1:0] OWNER_ICACHE = 2'b01;
    localparam logic [1:0] OWNER_DCACHE = 2'b10;

    // The AXI interface maps line fills to INCR and single accesses to FIXED.
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [RD_ADDR_W-1:0] addr;
        logic [RD_TYPE_W-1:0] rtype;
    } rd_cmd_t;

    function automatic logic [1:0] owner_of(input arb_state_e state);
        case (state)
            ST_BUSY_I: owner_of = OWNER_ICACHE;
            ST_BUSY_D: owner_of = OWNER_DCACHE;
            default:   owner_of = OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rd_age_counter.sv
// Saturating icache wait counter; flags starvation once the count reaches STARVE_LIMIT.
// Clear wins over increment so a handshake always restarts the aging window.
module rd_age_counter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             starved
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign starved = (cnt_q >= LIMIT);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates the single sram-like AXI read port between icache and dcache read requesters.
// A grant lasts from the request handshake through the rlast beat; dcache wins unless icache is starved.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 icache_rd_req,
    input  logic [RD_ADDR_W-1:0] icache_rd_addr,
    input  logic [RD_TYPE_W-1:0] icache_rd_type,
    output logic                 icache_rd_ready,
    output logic [RD_DATA_W-1:0] icache_rdata,
    output logic                 icache_rlast,
    output logic                 icache_rvalid,

    input  logic                 dcache_rd_req,
    input  logic [RD_ADDR_W-1:0] dcache_rd_addr,
    input  logic [RD_TYPE_W-1:0] dcache_rd_type,
    output logic                 dcache_rd_ready,
    output logic [RD_DATA_W-1:0] dcache_rdata,
    output logic                 dcache_rlast,
    output logic                 dcache_rvalid,

    output logic                 rd_req,
    output logic [RD_ADDR_W-1:0] rd_addr,
    output logic [RD_TYPE_W-1:0] rd_type,
    input  logic                 rd_ready,
    input  logic [RD_DATA_W-1:0] rdata,
    input  logic                 rlast,
    input  logic                 rvalid,

    output logic [1:0]           owner,
    output logic                 arb_err
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             arb_err_q;
    logic             arb_err_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             starved;
    logic             age_inc;
    logic             icache_wins;
    logic             dcache_wins;
    logic             orphan_beat;
    rd_cmd_t          icache_cmd;
    rd_cmd_t          dcache_cmd;

    assign icache_cmd = '{addr: icache_rd_addr, rtype: icache_rd_type};
    assign dcache_cmd = '{addr: dcache_rd_addr, rtype: dcache_rd_type};

    // Dcache has priority unless icache has aged past the starvation limit.
    assign icache_wins = icache_rd_req && (!dcache_rd_req || starved);
    assign dcache_wins = dcache_rd_req && !icache_wins;

    rd_age_counter #(
        .CNT_W        (CNT_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .clr     (icache_rd_ready),
        .inc     (age_inc),
        .cnt     (wait_cnt),
        .starved (starved)
    );

    always_comb begin
        state_d         = state_q;
        orphan_beat     = 1'b0;
        rd_req          = 1'b0;
        rd_addr         = '0;
        rd_type         = '0;
        icache_rd_ready = 1'b0;
        dcache_rd_ready = 1'b0;
        icache_rvalid   = 1'b0;
        icache_rlast    = 1'b0;
        icache_rdata    = '0;
        dcache_rvalid   = 1'b0;
        dcache_rlast    = 1'b0;
        dcache_rdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (icache_wins) begin
                    rd_req          = 1'b1;
                    rd_addr         = icache_cmd.addr;
                    rd_type         = icache_cmd.rtype;
                    icache_rd_ready = rd_ready;
                    if (rd_ready) begin
                        state_d = ST_BUSY_I;
                    end
                end else if (dcache_wins) begin
                    rd_req          = 1'b1;
                    rd_addr         = dcache_cmd.addr;
                    rd_type         = dcache_cmd.rtype;
                    dcache_rd_ready = rd_ready;
                    if (rd_ready) begin
                        state_d = ST_BUSY_D;
                    end
                end
                // No transaction is outstanding, so any beat here has nowhere to go.
                orphan_beat = rvalid;
            end
            ST_BUSY_I: begin
                icache_rvalid = rvalid;
                icache_rlast  = rlast;
                icache_rdata  = rdata;
                if (rvalid && rlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_D: begin
                dcache_rvalid = rvalid;
                dcache_rlast  = rlast;
                dcache_rdata  = rdata;
                if (rvalid && rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold every output at its reset value while rst is asserted.
        if (rst) begin
            state_d         = ST_IDLE;
            orphan_beat     = 1'b0;
            rd_req          = 1'b0;
            rd_addr         = '0;
            rd_type         = '0;
            icache_rd_ready = 1'b0;
            dcache_rd_ready = 1'b0;
            icache_rvalid   = 1'b0;
            icache_rlast    = 1'b0;
            icache_rdata    = '0;
            dcache_rvalid   = 1'b0;
            dcache_rlast    = 1'b0;
            dcache_rdata    = '0;
        end

        // Icache ages only while it waits on the shared port, never during its own burst.
        age_inc   = icache_rd_req && !icache_rd_ready &&
                    ((state_q == ST_IDLE) || (state_q == ST_BUSY_D));
        arb_err_d = arb_err_q || orphan_beat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            arb_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign owner   = owner_of(state_q);
    assign arb_err = arb_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios with a beat scoreboard.
// Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int unsigned STARVE = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ireq = 1'b0, dreq = 1'b0;
    logic [63:0] iaddr = '0, daddr = '0;
    logic [2:0]  itype = '0, dtype = '0;
    logic        icache_rd_ready, icache_rlast, icache_rvalid;
    logic        dcache_rd_ready, dcache_rlast, dcache_rvalid;
    logic [63:0] icache_rdata, dcache_rdata;
    logic        rd_req;
    logic [63:0] rd_addr;
    logic [2:0]  rd_type;
    logic        rd_ready = 1'b0;
    logic [63:0] rdata = '0;
    logic        rlast = 1'b0, rvalid = 1'b0;
    logic [1:0]  owner;
    logic        arb_err;
    logic [4:0]  ctl;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  dest;
        logic [63:0] data;
        logic        last;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    assign ctl = {rd_req, icache_rd_ready, dcache_rd_ready, owner};

    axi_rd_arbiter #(.STARVE_LIMIT(STARVE), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .icache_rd_req   (ireq),
        .icache_rd_addr  (iaddr),
        .icache_rd_type  (itype),
        .icache_rd_ready (icache_rd_ready),
        .icache_rdata    (icache_rdata),
        .icache_rlast    (icache_rlast),
        .icache_rvalid   (icache_rvalid),
        .dcache_rd_req   (dreq),
        .dcache_rd_addr  (daddr),
        .dcache_rd_type  (dtype),
        .dcache_rd_ready (dcache_rd_ready),
        .dcache_rdata    (dcache_rdata),
        .dcache_rlast    (dcache_rlast),
        .dcache_rvalid   (dcache_rvalid),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_type         (rd_type),
        .rd_ready        (rd_ready),
        .rdata           (rdata),
        .rlast           (rlast),
        .rvalid          (rvalid),
        .owner           (owner),
        .arb_err         (arb_err)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
    endtask

    task automatic settle();
        #4;
    endtask

    // Pops the scoreboard whenever either requester sees a beat.
    task automatic sample_beat();
        logic [1:0]  obs;
        logic [63:0] d;
        logic        l;
        logic [64:0] quiet;
        beat_t       e;
        obs = {dcache_rvalid, icache_rvalid};
        vectors++;
        if (obs == 2'b11) begin
            miscompares++;
            $display("FAIL beat_dest: both rvalids high, required one");
        end else if (obs == OWNER_NONE) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                miscompares++;
                $display("FAIL beat_missing: got no beat, required dest %b data %h", e.dest, e.data);
            end
            vectors++;
            if ({icache_rdata, icache_rlast, dcache_rdata, dcache_rlast} !== 130'd0) begin
                miscompares++;
                $display("FAIL beat_quiet: rdata/rlast not zero with no rvalid");
            end
        end else begin
            d = (obs == OWNER_ICACHE) ? icache_rdata : dcache_rdata;
            l = (obs == OWNER_ICACHE) ? icache_rlast : dcache_rlast;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got dest %b data %h, required none", obs, d);
            end else begin
                e = exp_q.pop_front();
                if ({obs, d, l} !== {e.dest, e.data, e.last}) begin
                    miscompares++;
                    $display("FAIL beat_route: got %b/%h/%b required %b/%h/%b",
                             obs, d, l, e.dest, e.data, e.last);
                end
            end
            quiet = (obs == OWNER_ICACHE) ? {dcache_rdata, dcache_rlast} : {icache_rdata, icache_rlast};
            vectors++;
            if (quiet !== 65'd0) begin
                miscompares++;
                $display("FAIL beat_nonowner: got %h required 0", quiet);
            end
        end
    endtask

    task automatic do_beat(input logic [1:0] dest, input logic [63:0] data, input logic last);
        beat_t e;
        rvalid = 1'b1;
        rdata  = data;
        rlast  = last;
        if (dest != OWNER_NONE) begin
            e = '{dest: dest, data: data, last: last};
            exp_q.push_back(e);
        end
        settle();
        sample_beat();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        vectors++;
        if ({ctl, arb_err, icache_rvalid, dcache_rvalid, icache_rlast, dcache_rlast} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b required 0",
                     {ctl, arb_err, icache_rvalid, dcache_rvalid, icache_rlast, dcache_rlast});
        end
        vectors++;
        if ({icache_rdata, dcache_rdata, rd_addr, rd_type, dut.wait_cnt} !== 203'd0) begin
            miscompares++;
            $display("FAIL reset_data: rdata/rd_addr/rd_type/wait_cnt not zero");
        end
    endtask

    task automatic test_dcache_alone();
        next_cycle();
        dreq = 1'b1; daddr = 64'h0000_0000_8000_0040; dtype = RD_TYPE_LINE; rd_ready = 1'b1;
        settle();
        vectors++;
        if ({ctl, rd_addr, rd_type} !== {1'b1, 1'b0, 1'b1, OWNER_NONE, 64'h8000_0040, RD_TYPE_LINE}) begin
            miscompares++;
            $display("FAIL d_alone_req: got %b/%h/%0d required 10100/80000040/4", ctl, rd_addr, rd_type);
        end
        next_cycle();
        dreq = 1'b0;
        do_beat(OWNER_DCACHE, 64'hD1D1_0000_0000_0001, 1'b0);
        vectors++;
        if (ctl !== {3'b000, OWNER_DCACHE}) begin
            miscompares++;
            $display("FAIL d_alone_busy: got %b required 00010", ctl);
        end
        next_cycle();
        do_beat(OWNER_DCACHE, 64'hD1D1_0000_0000_0002, 1'b1);
        next_cycle();
        settle();
        vectors++;
        if (ctl !== 5'b00000) begin
            miscompares++;
            $display("FAIL d_alone_idle: got %b required 00000", ctl);
        end
    endtask

    task automatic test_priority();
        next_cycle();
        ireq = 1'b1; iaddr = 64'h1000; itype = RD_TYPE_LINE;
        dreq = 1'b1; daddr = 64'h2000; dtype = RD_TYPE_B8; rd_ready = 1'b1;
        settle();
        vectors++;
        if ({ctl, rd_addr} !== {1'b1, 1'b0, 1'b1, OWNER_NONE, 64'h2000}) begin
            miscompares++;
            $display("FAIL prio_d_wins: got %b/%h required 10100/2000", ctl, rd_addr);
        end
        next_cycle();
        dreq = 1'b0;
        do_beat(OWNER_DCACHE, 64'hD2, 1'b1);
        vectors++;
        if (ctl !== {3'b000, OWNER_DCACHE}) begin
            miscompares++;
            $display("FAIL prio_busy_d: got %b required 00010", ctl);
        end
        next_cycle();
        settle();
        vectors++;
        if ({ctl, rd_addr, dut.wait_cnt} !== {1'b1, 1'b1, 1'b0, OWNER_NONE, 64'h1000, 8'd2}) begin
            miscompares++;
            $display("FAIL prio_i_after_bubble: got %b/%h/%0d required 11000/1000/2", ctl, rd_addr, dut.wait_cnt);
        end
        next_cycle();
        ireq = 1'b0;
        do_beat(OWNER_ICACHE, 64'h1111, 1'b0);
        vectors++;
        if ({ctl, dut.wait_cnt} !== {3'b000, OWNER_ICACHE, 8'd0}) begin
            miscompares++;
            $display("FAIL prio_busy_i: got %b/%0d required 00001/0", ctl, dut.wait_cnt);
        end
        next_cycle();
        do_beat(OWNER_ICACHE, 64'h2222, 1'b1);
    endtask

    task automatic test_starvation();
        int   exp_cnt;
        logic win_i;
        exp_cnt = 0;
        win_i   = 1'b0;
        next_cycle();
        ireq = 1'b1; iaddr = 64'h4000; itype = RD_TYPE_LINE;
        dreq = 1'b1; daddr = 64'h5000; dtype = RD_TYPE_B8; rd_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            settle();
            win_i = (exp_cnt >= STARVE);
            vectors++;
            if (ctl !== (win_i ? 5'b11000 : 5'b10100)) begin
                miscompares++;
                $display("FAIL starve_grant[%0d]: got %b required %b", t, ctl, win_i ? 5'b11000 : 5'b10100);
            end
            vectors++;
            if (dut.wait_cnt !== 8'(exp_cnt)) begin
                miscompares++;
                $display("FAIL starve_cnt[%0d]: got %0d required %0d", t, dut.wait_cnt, exp_cnt);
            end
            if (win_i) break;
            exp_cnt++;
            next_cycle();
            do_beat(OWNER_DCACHE, 64'hD000 + 64'(t), 1'b1);
            exp_cnt++;
            next_cycle();
        end
        next_cycle();
        ireq = 1'b0; dreq = 1'b0;
        do_beat(OWNER_ICACHE, 64'h1F1F, 1'b1);
        vectors++;
        if ({ctl, dut.wait_cnt} !== {3'b000, OWNER_ICACHE, 8'd0}) begin
            miscompares++;
            $display("FAIL starve_clear: got %b/%0d required 00001/0", ctl, dut.wait_cnt);
        end
        next_cycle();
        settle();
    endtask

    task automatic test_ready_low();
        next_cycle();
        ireq = 1'b1; iaddr = 64'h3000; itype = RD_TYPE_B4; rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            vectors++;
            if ({ctl, rd_addr, rd_type, dut.wait_cnt} !==
                {1'b1, 1'b0, 1'b0, OWNER_NONE, 64'h3000, RD_TYPE_B4, 8'(k)}) begin
                miscompares++;
                $display("FAIL ready_low[%0d]: got %b/%h/%0d/%0d required 10000/3000/2/%0d",
                         k, ctl, rd_addr, rd_type, dut.wait_cnt, k);
            end
            next_cycle();
        end
        rd_ready = 1'b1;
        settle();
        vectors++;
        if ({ctl, dut.wait_cnt} !== {1'b1, 1'b1, 1'b0, OWNER_NONE, 8'd5}) begin
            miscompares++;
            $display("FAIL ready_rise: got %b/%0d required 11000/5", ctl, dut.wait_cnt);
        end
        next_cycle();
        ireq = 1'b0;
        do_beat(OWNER_ICACHE, 64'h3333, 1'b1);
        vectors++;
        if ({ctl, dut.wait_cnt} !== {3'b000, OWNER_ICACHE, 8'd0}) begin
            miscompares++;
            $display("FAIL ready_busy_i: got %b/%0d required 00001/0", ctl, dut.wait_cnt);
        end
        next_cycle();
        settle();
    endtask

    task automatic test_orphan_beat();
        next_cycle();
        do_beat(OWNER_NONE, 64'hDEAD_BEEF, 1'b1);
        vectors++;
        if (arb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL orphan_pre: arb_err got %b required 0", arb_err);
        end
        next_cycle();
        settle();
        vectors++;
        if ({arb_err, owner} !== 3'b100) begin
            miscompares++;
            $display("FAIL orphan_set: arb_err/owner got %b required 100", {arb_err, owner});
        end
        repeat (3) next_cycle();
        settle();
        vectors++;
        if (arb_err !== 1'b1) begin
            miscompares++;
            $display("FAIL orphan_sticky: arb_err got %b required 1", arb_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        next_cycle();
        ireq = 1'b1; iaddr = 64'h6000; itype = RD_TYPE_LINE; rd_ready = 1'b1;
        settle();
        next_cycle();
        ireq = 1'b0;
        do_beat(OWNER_ICACHE, 64'h6001, 1'b0);
        vectors++;
        if (ctl !== {3'b000, OWNER_ICACHE}) begin
            miscompares++;
            $display("FAIL rst_mid_busy: got %b required 00001", ctl);
        end
        next_cycle();
        rst = 1'b1;
        settle();
        next_cycle();
        rst = 1'b0;
        settle();
        vectors++;
        if ({ctl, arb_err, icache_rvalid, dcache_rvalid, icache_rlast, dcache_rlast,
             icache_rdata, dcache_rdata, dut.wait_cnt} !== 146'd0) begin
            miscompares++;
            $display("FAIL rst_mid_state: got ctl %b arb_err %b required all zero", ctl, arb_err);
        end
        do_beat(OWNER_NONE, 64'h6002, 1'b1);
        next_cycle();
        dreq = 1'b1; daddr = 64'h7000; dtype = RD_TYPE_B2;
        settle();
        vectors++;
        if ({arb_err, ctl, rd_addr} !== {1'b1, 1'b1, 1'b0, 1'b1, OWNER_NONE, 64'h7000}) begin
            miscompares++;
            $display("FAIL rst_mid_regrant: got %b/%b/%h required 1/10100/7000", arb_err, ctl, rd_addr);
        end
        next_cycle();
        dreq = 1'b0;
        do_beat(OWNER_DCACHE, 64'h7777, 1'b1);
        next_cycle();
        settle();
        vectors++;
        if ({ctl, exp_q.size() == 0} !== 6'b000001) begin
            miscompares++;
            $display("FAIL final_idle: ctl got %b, %0d beats outstanding, required 00000/0", ctl, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dcache_alone();
        test_priority();
        test_starvation();
        test_ready_low();
        test_orphan_beat();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
